pcie_stp_sdp_scheduler: RTL

- Per-cycle framing-token scheduler for the 128b/130b transmit path, sitting upstream of the STP/SDP lane-placement stage.
- Arbitrates between a TLP requester (STP token) and a DLLP requester (SDP token).
- Tracks how many DW of the in-flight packet remain and starts each new packet on the first free 4N-lane slot.
- Emits a registered per-slot map (start / token type / idle fill) every accepted cycle.

---
 rtl/pcie_stp_sdp_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pcie_stp_sdp_scheduler.sv
`timescale 1ns/1ps
// STP/SDP framing-token scheduler for the 128b/130b transmit path: arbitrates TLP vs DLLP
// starts and emits a registered per-slot map (start / token type / idle fill) per accepted cycle.
module pcie_stp_sdp_scheduler #(
    parameter int LINK_WIDTH     = 16,
    parameter int MAX_DLLP_BURST = 3,
    parameter int LEN_W          = 11
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tlp_req,
    input  logic [LEN_W-1:0]          tlp_len_dw,
    output logic                      tlp_gnt,
    input  logic                      dllp_req,
    output logic                      dllp_gnt,
    input  logic                      tx_ready,
    output logic                      out_valid,
    output logic [LINK_WIDTH/4-1:0]   sop_mask,
    output logic                      sdp_flag,
    output logic [LINK_WIDTH/4-1:0]   idle_mask,
    output logic                      len_err
);

    localparam int S     = LINK_WIDTH / 4;
    localparam int CNT_W = $clog2(MAX_DLLP_BURST + 2);

    localparam logic [LEN_W-1:0] S_LEN   = LEN_W'(S);
    localparam logic [LEN_W:0]   S_END   = (LEN_W+1)'(S);
    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DLLP_BURST);

    // Anything shorter than STP + LCRC cannot be framed; it is sent as a 2 DW packet.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len < MIN_LEN) ? MIN_LEN : len;
    endfunction

    logic [LEN_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] dllp_cnt_q, dllp_cnt_d;
    logic             out_valid_q;
    logic [S-1:0]     sop_q, sop_d;
    logic [S-1:0]     idle_q, idle_d;
    logic             sdp_q, sdp_d;
    logic             tlp_gnt_q, tlp_gnt_d;
    logic             dllp_gnt_q, dllp_gnt_d;
    logic             len_err_q, len_err_d;

    logic             tlp_elig;
    logic             dllp_elig;
    logic             cont_full;
    logic             win_tlp;
    logic             win_dllp;
    logic             win_any;
    logic [LEN_W-1:0] pkt_len;
    logic [LEN_W:0]   pkt_end;

    always_comb begin
        tlp_elig   = tlp_req & ~tlp_gnt_q;
        dllp_elig  = dllp_req & ~dllp_gnt_q;
        cont_full  = (rem_q >= S_LEN);
        win_tlp    = 1'b0;
        win_dllp   = 1'b0;
        sop_d      = '0;
        idle_d     = '0;
        rem_d      = rem_q;
        dllp_cnt_d = dllp_cnt_q;

        if (!cont_full) begin
            // DLLP first, unless the TLP has already waited out a full DLLP burst.
            if (tlp_elig && (!dllp_elig || (dllp_cnt_q == CNT_MAX))) begin
                win_tlp = 1'b1;
            end else if (dllp_elig) begin
                win_dllp = 1'b1;
            end
        end
        win_any = win_tlp | win_dllp;
        pkt_len = win_tlp ? clamp_len(tlp_len_dw) : MIN_LEN;
        pkt_end = {1'b0, rem_q} + {1'b0, pkt_len};

        if (cont_full) begin
            rem_d = rem_q - S_LEN;
        end else begin
            for (int k = 0; k < S; k++) begin
                sop_d[k]  = win_any && (rem_q == LEN_W'(k));
                idle_d[k] = (LEN_W'(k) >= rem_q) && !(win_any && ((LEN_W+1)'(k) < pkt_end));
            end
            rem_d = (win_any && (pkt_end > S_END)) ? LEN_W'(pkt_end - S_END) : '0;
        end

        if (win_tlp || !tlp_req) begin
            dllp_cnt_d = '0;
        end else if (win_dllp && (dllp_cnt_q != CNT_MAX)) begin
            dllp_cnt_d = dllp_cnt_q + CNT_W'(1);
        end

        sdp_d      = win_dllp;
        tlp_gnt_d  = win_tlp;
        dllp_gnt_d = win_dllp;
        len_err_d  = win_tlp && (tlp_len_dw < MIN_LEN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= '0;
            dllp_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            sop_q       <= '0;
            idle_q      <= '0;
            sdp_q       <= 1'b0;
            tlp_gnt_q   <= 1'b0;
            dllp_gnt_q  <= 1'b0;
            len_err_q   <= 1'b0;
        end else if (tx_ready) begin
            rem_q       <= rem_d;
            dllp_cnt_q  <= dllp_cnt_d;
            out_valid_q <= 1'b1;
            sop_q       <= sop_d;
            idle_q      <= idle_d;
            sdp_q       <= sdp_d;
            tlp_gnt_q   <= tlp_gnt_d;
            dllp_gnt_q  <= dllp_gnt_d;
            len_err_q   <= len_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sop_mask  = sop_q;
    assign idle_mask = idle_q;
    assign sdp_flag  = sdp_q;
    assign tlp_gnt   = tlp_gnt_q;
    assign dllp_gnt  = dllp_gnt_q;
    assign len_err   = len_err_q;

endmodule
